serializer_arbiter: RTL
=======================

SERIALIZER_ARBITER -- requirements
Module: serializer_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, data word width passed to serializer
- N_REQ, 4, number of requesters (2..8)
- FRAME_CYCLES, 10, clk cycles the serializer needs after a send pulse before it accepts the next word
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge
- rst, in, 1, asynchronous active-low reset
- req, in, N_REQ, per-requester request; bit i held high while requester i has a word pending
- req_data, in, N_REQ*WIDTH, word of requester i in bits [i*WIDTH +: WIDTH]
- ack, out, N_REQ, one-hot one-cycle pulse; word of that requester taken
- data, out, WIDTH, word driven to serializer data input
- send, out, 1, one-cycle start pulse to serializer
- busy, out, 1, high while a word is being sent or loaded
- grant_id, out, clog2(N_REQ), index of requester last granted

Function
REQ-003 FSM SHALL have states IDLE, LOAD, WAIT; all outputs SHALL be registered.
REQ-004 In IDLE with req != 0, the block SHALL select winner w by round-robin, searching from (last_grant+1) mod N_REQ upward with wrap-around, and enter LOAD next cycle.
REQ-005 In IDLE with req == 0, the block SHALL remain in IDLE; send, ack, busy = 0.
REQ-006 On entering LOAD, data SHALL equal req_data[w] as sampled in the IDLE decision cycle; send = 1, ack[w] = 1, busy = 1, grant_id = w, all for exactly that one cycle for send/ack.
REQ-007 LOAD SHALL always go to WAIT; WAIT SHALL last exactly FRAME_CYCLES cycles with busy = 1, send = 0, ack = 0, then return to IDLE.
REQ-008 Send pulse-to-pulse spacing SHALL therefore be at least FRAME_CYCLES+2 cycles (LOAD, FRAME_CYCLES x WAIT, IDLE decision).
REQ-009 data SHALL hold its value from LOAD until the next LOAD; it SHALL NOT change in WAIT or IDLE.
REQ-010 req SHALL be sampled only in IDLE; req changes during LOAD/WAIT SHALL have no effect; a req deasserted before the IDLE decision SHALL NOT be granted.
REQ-011 A requester whose ack has pulsed SHALL be treated as a new request if req is still high at the next IDLE decision (holding req after ack sends again).
REQ-012 With all req bits continuously high, grants SHALL rotate 0,1,...,N_REQ-1,0,... with no requester skipped.
REQ-013 The WAIT counter SHALL be wide enough for FRAME_CYCLES and SHALL NOT wrap; no other arithmetic overflow SHALL be observable.

Reset
REQ-014 While rst = 0: state = IDLE, data = 0, send = 0, ack = 0, busy = 0, grant_id = 0, last_grant = N_REQ-1 (so requester 0 has first priority).
REQ-015 Reset asserted during LOAD or WAIT SHALL abort the frame immediately; no ack or send SHALL follow deassertion until a new IDLE decision.
REQ-016 After rst rises, the first arbitration SHALL occur in the first clk edge with state IDLE.

Verification (N_REQ=4, WIDTH=8, FRAME_CYCLES=10)
REQ-017 Single request: req=0100, req_data[2]=8'hA5 at cycle 0 -> cycle 1 send=1, ack=0100, data=8'hA5, grant_id=2; busy high cycles 1..11; IDLE at 12.
REQ-018 Full contention: req=1111 held, words 8'h10/11/12/13 -> sends at cycles 1,13,25,37 with data 10,11,12,13, then 10 again at 49.
REQ-019 Late request: req[3] raised during WAIT of a requester-0 frame -> ignored until next IDLE; granted there with send 12 cycles after previous send.
REQ-020 Wrap priority: last_grant=3, req=1001 -> requester 0 granted first, then 3.
REQ-021 Reset mid-WAIT: rst=0 at cycle 5 of WAIT with req=0010 -> outputs zero during reset; after release, requester 1 granted on first IDLE cycle, data from current req_data[1].
REQ-022 Withdrawn request: req[1] pulsed high only during WAIT -> no ack[1], no send after frame ends.

Source files
------------

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that feeds one word at a time into a fixed-latency
// serializer. A grant produces a registered LOAD cycle (send/ack pulse, word
// on data) followed by FRAME_CYCLES WAIT cycles before the next decision.
module serializer_arbiter #(
  parameter int WIDTH        = 8,
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [WIDTH-1:0]           data,
  output logic                       send,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int GW = $clog2(N_REQ);
  // Sized to hold FRAME_CYCLES itself, so the terminal compare never wraps.
  localparam int CW = $clog2(FRAME_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [GW-1:0]     last_grant, last_d;
  logic [GW-1:0]     grant_d;
  logic [WIDTH-1:0]  data_d;
  logic [N_REQ-1:0]  ack_d;
  logic              send_d;
  logic              busy_d;
  logic              found;
  logic [GW-1:0]     win;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && req[(int'(last_grant) + i) % N_REQ]) begin
        found = 1'b1;
        win   = GW'((int'(last_grant) + i) % N_REQ);
      end
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state;
    cnt_d   = cnt;
    last_d  = last_grant;
    grant_d = grant_id;
    data_d  = data;
    ack_d   = '0;
    send_d  = 1'b0;
    busy_d  = busy;
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (found) begin
          state_d    = LOAD;
          data_d     = req_data[win*WIDTH +: WIDTH];
          send_d     = 1'b1;
          ack_d[win] = 1'b1;
          busy_d     = 1'b1;
          grant_d    = win;
          last_d     = win;
        end
      end
      LOAD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt == CW'(FRAME_CYCLES - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GW'(N_REQ - 1);
      grant_id   <= '0;
      data       <= '0;
      ack        <= '0;
      send       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last_grant <= last_d;
      grant_id   <= grant_d;
      data       <= data_d;
      ack        <= ack_d;
      send       <= send_d;
      busy       <= busy_d;
    end
  end

endmodule
